// File: rtl/lpimo_rr_arbiter.sv
// lpimo_rr_arbiter: shares one LPIMO master port among NUM_REQ requesters, with an in-order tag FIFO
// that routes each response back to its originator. Define LPIMO_ARB_FIXED_PRIORITY_EN for fixed priority.
module lpimo_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BW_QDATA  = 64,
    parameter int BW_YDATA  = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_qvalid,
    output logic [NUM_REQ-1:0]            req_qready,
    input  logic [NUM_REQ*BW_QDATA-1:0]   req_qdata,
    output logic [NUM_REQ-1:0]            req_yvalid,
    input  logic [NUM_REQ-1:0]            req_yready,
    output logic [BW_YDATA-1:0]           req_ydata,
    output logic                          mst_qvalid,
    input  logic                          mst_qready,
    output logic [BW_QDATA-1:0]           mst_qdata,
    input  logic                          mst_yvalid,
    output logic                          mst_yready,
    input  logic [BW_YDATA-1:0]           mst_ydata,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          orphan_err
);
    localparam int RW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TAG_DEPTH);
    localparam int CW = TW + 1;

    logic [RW-1:0] start_idx;
    logic [RW-1:0] cand;
    logic [RW-1:0] winner;
    logic          found;
    logic          load_en;
    logic          grant_ok;
    logic          grant;

    logic [RW-1:0] tag_mem [TAG_DEPTH];
    logic [TW-1:0] wr_ptr;
    logic [TW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [RW-1:0] head;
    logic          fifo_empty;
    logic          pop;

`ifdef LPIMO_ARB_FIXED_PRIORITY_EN
    assign start_idx = '0;
`else
    logic [RW-1:0] rr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= (winner == RW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    assign start_idx = rr_ptr;
`endif

    // Rotating search: first requester with qvalid set, starting at start_idx.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        found  = 1'b0;
        winner = '0;
        cand   = start_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_qvalid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            // NOTE: cand is blocking here because each iteration must see the previous iteration's value.
            cand = (cand == RW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Full is judged on the registered count, so a pop this cycle only frees a tag next cycle.
    assign load_en    = !mst_qvalid || mst_qready;
    assign grant_ok   = load_en && (count < CW'(TAG_DEPTH));
    assign grant      = grant_ok && found;
    assign req_qready = grant ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_qvalid <= 1'b0;
            mst_qdata  <= '0;
        end else if (grant) begin
            mst_qvalid <= 1'b1;
            mst_qdata  <= req_qdata[winner*BW_QDATA +: BW_QDATA];
        end else if (mst_qready) begin
            mst_qvalid <= 1'b0;
        end
    end

    assign head       = tag_mem[rd_ptr];
    assign fifo_empty = (count == '0);

    // An orphan beat is accepted and dropped so the bridge never stalls on it.
    always_comb begin
        req_yvalid = '0;
        mst_yready = 1'b1;
        if (!fifo_empty) begin
            mst_yready = req_yready[head];
            if (mst_yvalid)
                req_yvalid = NUM_REQ'(1) << head;
        end
    end

    assign req_ydata = mst_ydata;
    assign pop       = mst_yvalid && mst_yready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (grant)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (grant && !pop)
                count <= count + 1'b1;
            else if (pop && !grant)
                count <= count - 1'b1;
            if (mst_yvalid && fifo_empty)
                orphan_err <= 1'b1;
        end
    end

    // NOTE: tag storage has no reset; entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (grant)
            tag_mem[wr_ptr] <= winner;
    end

    assign outstanding = count;

endmodule

// File: tb/tb_lpimo_rr_arbiter.sv
// tb_lpimo_rr_arbiter: directed stimulus with a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_lpimo_rr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int BW_QDATA  = 64;
    localparam int BW_YDATA  = 32;
    localparam int TAG_DEPTH = 4;
    localparam int CW        = $clog2(TAG_DEPTH) + 1;

    logic                        clk;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_qvalid;
    logic [NUM_REQ-1:0]          req_qready;
    logic [NUM_REQ*BW_QDATA-1:0] req_qdata;
    logic [NUM_REQ-1:0]          req_yvalid;
    logic [NUM_REQ-1:0]          req_yready;
    logic [BW_YDATA-1:0]         req_ydata;
    logic                        mst_qvalid;
    logic                        mst_qready;
    logic [BW_QDATA-1:0]         mst_qdata;
    logic                        mst_yvalid;
    logic                        mst_yready;
    logic [BW_YDATA-1:0]         mst_ydata;
    logic [CW-1:0]               outstanding;
    logic                        orphan_err;

    lpimo_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .BW_QDATA (BW_QDATA),
        .BW_YDATA (BW_YDATA),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_qvalid (req_qvalid),
        .req_qready (req_qready),
        .req_qdata  (req_qdata),
        .req_yvalid (req_yvalid),
        .req_yready (req_yready),
        .req_ydata  (req_ydata),
        .mst_qvalid (mst_qvalid),
        .mst_qready (mst_qready),
        .mst_qdata  (mst_qdata),
        .mst_yvalid (mst_yvalid),
        .mst_yready (mst_yready),
        .mst_ydata  (mst_ydata),
        .outstanding(outstanding),
        .orphan_err (orphan_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] onehot(input int i);
        return 64'd1 << i;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int i, input logic [BW_QDATA-1:0] v);
        req_qdata[i*BW_QDATA +: BW_QDATA] = v;
    endtask

    // Reference model: tags as a queue, output stage as a valid/data pair.
    int                  m_q[$];
    int                  m_ptr    = 0;
    bit                  m_qvalid = 1'b0;
    logic [BW_QDATA-1:0] m_qdata  = '0;
    bit                  m_orphan = 1'b0;
    bit                  model_on = 1'b0;

    bit                  p_rst    = 1'b1;
    bit                  p_grant  = 1'b0;
    bit                  p_pop    = 1'b0;
    bit                  p_clr    = 1'b0;
    bit                  p_orphan = 1'b0;
    int                  p_w      = 0;
    logic [BW_QDATA-1:0] p_data   = '0;

    always @(negedge clk) begin : cmp
        int                 start;
        int                 w;
        bit                 found;
        bit                 gok;
        logic [NUM_REQ-1:0] e_qready;
        logic [NUM_REQ-1:0] e_yvalid;
        logic               e_yready;
        found = 1'b0;
        w     = 0;
`ifdef LPIMO_ARB_FIXED_PRIORITY_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_qvalid[(start + i) % NUM_REQ]) begin
                found = 1'b1;
                w     = (start + i) % NUM_REQ;
            end
        end
        gok      = (!m_qvalid || mst_qready) && (m_q.size() < TAG_DEPTH);
        e_qready = (gok && found) ? (NUM_REQ'(1) << w) : '0;
        if (m_q.size() == 0) begin
            e_yvalid = '0;
            e_yready = 1'b1;
        end else begin
            e_yvalid = mst_yvalid ? (NUM_REQ'(1) << m_q[0]) : '0;
            e_yready = req_yready[m_q[0]];
        end
        if (model_on) begin
            check("m_req_qready",  64'(req_qready),  64'(e_qready));
            check("m_req_yvalid",  64'(req_yvalid),  64'(e_yvalid));
            check("m_mst_yready",  64'(mst_yready),  64'(e_yready));
            check("m_req_ydata",   64'(req_ydata),   64'(mst_ydata));
            check("m_mst_qvalid",  64'(mst_qvalid),  64'(m_qvalid));
            check("m_mst_qdata",   64'(mst_qdata),   64'(m_qdata));
            check("m_outstanding", 64'(outstanding), 64'(m_q.size()));
            check("m_orphan_err",  64'(orphan_err),  64'(m_orphan));
        end
        p_rst    = rst;
        p_grant  = gok && found;
        p_w      = w;
        p_data   = req_qdata[w*BW_QDATA +: BW_QDATA];
        p_pop    = mst_yvalid && e_yready && (m_q.size() > 0);
        p_clr    = mst_qready;
        p_orphan = mst_yvalid && (m_q.size() == 0);
    end

    always @(posedge clk) begin
        if (p_rst) begin
            m_q.delete();
            m_ptr    = 0;
            m_qvalid = 1'b0;
            m_qdata  = '0;
            m_orphan = 1'b0;
        end else begin
            if (p_pop)
                void'(m_q.pop_front());
            if (p_grant) begin
                m_q.push_back(p_w);
                m_qdata  = p_data;
                m_qvalid = 1'b1;
                m_ptr    = (p_w + 1) % NUM_REQ;
            end else if (p_clr) begin
                m_qvalid = 1'b0;
            end
            if (p_orphan)
                m_orphan = 1'b1;
        end
    end

    int rr_order[6];

    initial begin
`ifdef LPIMO_ARB_FIXED_PRIORITY_EN
        rr_order = '{0, 0, 0, 0, 0, 0};
`else
        rr_order = '{0, 1, 2, 3, 0, 1};
`endif
        rst        = 1'b1;
        req_qvalid = '0;
        req_qdata  = '0;
        req_yready = '0;
        mst_qready = 1'b0;
        mst_yvalid = 1'b0;
        mst_ydata  = '0;
        tick;
        tick;
        rst      = 1'b0;
        model_on = 1'b1;
        #1;
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_qvalid",      64'(mst_qvalid),  64'd0);
        check("rst_qdata",       64'(mst_qdata),   64'd0);
        check("rst_orphan",      64'(orphan_err),  64'd0);

        // Fairness: all requesters valid, responses returned as soon as tags exist.
        for (int i = 0; i < NUM_REQ; i++)
            set_q(i, 64'h100 + 64'(i));
        req_qvalid = '1;
        mst_qready = 1'b1;
        req_yready = '1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_grant", 64'(req_qready), onehot(rr_order[k]));
            if (k > 0)
                check("rr_route", 64'(req_yvalid), onehot(rr_order[k-1]));
            tick;
            check("rr_qdata", 64'(mst_qdata), 64'h100 + 64'(rr_order[k]));
            mst_yvalid = 1'b1;
        end
        req_qvalid = '0;
        tick;
        mst_yvalid = 1'b0;
        #1;
        check("rr_drained", 64'(outstanding), 64'd0);
        check("rr_qvalid_off", 64'(mst_qvalid), 64'd0);

        // Tag-full stall with requester 2 streaming.
        req_qvalid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            set_q(2, 64'h200 + 64'(k));
            #1;
            check("full_grant", 64'(req_qready), onehot(2));
            tick;
        end
        #1;
        check("full_stall", 64'(req_qready), 64'd0);
        check("full_count", 64'(outstanding), 64'd4);
        mst_yvalid = 1'b1;
        mst_ydata  = 32'h77;
        #1;
        check("full_pop_nogrant", 64'(req_qready), 64'd0);
        check("full_pop_route",   64'(req_yvalid), onehot(2));
        check("full_pop_yready",  64'(mst_yready), 64'd1);
        tick;
        mst_yvalid = 1'b0;
        #1;
        check("full_after_pop_count", 64'(outstanding), 64'd3);
        check("full_after_pop_grant", 64'(req_qready), onehot(2));
        tick;
        #1;
        check("full_refill", 64'(outstanding), 64'd4);
        req_qvalid = '0;
        mst_yvalid = 1'b1;
        repeat (4) tick;
        mst_yvalid = 1'b0;
        #1;
        check("full_drained", 64'(outstanding), 64'd0);

        // Backpressure: req1 parcel held while bridge stalls, req3 granted on release.
        set_q(1, 64'hA5);
        req_qvalid = 4'b0010;
        #1;
        check("bp_grant1", 64'(req_qready), onehot(1));
        tick;
        mst_qready = 1'b0;
        set_q(3, 64'h5A);
        req_qvalid = 4'b1000;
        repeat (3) begin
            #1;
            check("bp_hold_valid", 64'(mst_qvalid), 64'd1);
            check("bp_hold_data",  64'(mst_qdata),  64'hA5);
            check("bp_no_grant",   64'(req_qready), 64'd0);
            tick;
        end
        mst_qready = 1'b1;
        #1;
        check("bp_release_grant", 64'(req_qready), onehot(3));
        tick;
        check("bp_next_data",  64'(mst_qdata),  64'h5A);
        check("bp_next_valid", 64'(mst_qvalid), 64'd1);
        req_qvalid = '0;
        tick;
        mst_yvalid = 1'b1;
        #1;
        check("bp_route1", 64'(req_yvalid), onehot(1));
        tick;
        #1;
        check("bp_route3", 64'(req_yvalid), onehot(3));
        tick;
        mst_yvalid = 1'b0;

        // Response routing for grants 2, 0, 3.
        req_qvalid = 4'b0100;
        #1;
        check("route_g2", 64'(req_qready), onehot(2));
        tick;
        req_qvalid = 4'b0001;
        #1;
        check("route_g0", 64'(req_qready), onehot(0));
        tick;
        req_qvalid = 4'b1000;
        #1;
        check("route_g3", 64'(req_qready), onehot(3));
        tick;
        req_qvalid = '0;
        tick;
        mst_yvalid = 1'b1;
        mst_ydata  = 32'h11;
        req_yready = '1;
        #1;
        check("route_y0_valid", 64'(req_yvalid), 64'b0100);
        check("route_y0_data",  64'(req_ydata),  64'h11);
        check("route_y0_ready", 64'(mst_yready), 64'd1);
        tick;
        mst_ydata  = 32'h22;
        req_yready = 4'b1110;
        #1;
        check("route_y1_valid", 64'(req_yvalid), 64'b0001);
        check("route_y1_stall", 64'(mst_yready), 64'd0);
        tick;
        #1;
        check("route_y1_held_cnt",  64'(outstanding), 64'd2);
        check("route_y1_held_head", 64'(req_yvalid),  64'b0001);
        req_yready = '1;
        #1;
        check("route_y1_ready", 64'(mst_yready), 64'd1);
        tick;
        mst_ydata = 32'h33;
        #1;
        check("route_y2_valid", 64'(req_yvalid), 64'b1000);
        check("route_y2_data",  64'(req_ydata),  64'h33);
        tick;
        mst_yvalid = 1'b0;
        #1;
        check("route_drained", 64'(outstanding), 64'd0);

        // Orphan response.
        mst_yvalid = 1'b1;
        mst_ydata  = 32'hDEAD;
        #1;
        check("orphan_yready", 64'(mst_yready), 64'd1);
        check("orphan_yvalid", 64'(req_yvalid), 64'd0);
        check("orphan_before", 64'(orphan_err), 64'd0);
        tick;
        mst_yvalid = 1'b0;
        #1;
        check("orphan_set", 64'(orphan_err), 64'd1);
        repeat (3) tick;
        check("orphan_held", 64'(orphan_err), 64'd1);

        // Reset mid-burst with three outstanding and a held request.
        set_q(0, 64'hC0);
        req_qvalid = 4'b0001;
        mst_qready = 1'b1;
        repeat (3) tick;
        req_qvalid = '0;
        mst_qready = 1'b0;
        #1;
        check("prerst_count",  64'(outstanding), 64'd3);
        check("prerst_qvalid", 64'(mst_qvalid),  64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("postrst_qvalid", 64'(mst_qvalid),  64'd0);
        check("postrst_count",  64'(outstanding), 64'd0);
        check("postrst_orphan", 64'(orphan_err),  64'd0);
        check("postrst_qready", 64'(req_qready),  64'd0);
        tick;
        check("postrst_idle_qready", 64'(req_qready), 64'd0);
        set_q(2, 64'h2C);
        req_qvalid = 4'b0100;
        #1;
        check("postrst_grant", 64'(req_qready), onehot(2));
        tick;
        check("postrst_qdata", 64'(mst_qdata), 64'h2C);
        req_qvalid = '0;
        mst_qready = 1'b1;
        mst_yvalid = 1'b1;
        tick;
        mst_yvalid = 1'b0;
        #1;
        check("final_drained", 64'(outstanding), 64'd0);
        repeat (2) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
